// File: rtl/core_pkg.sv
// Core-wide integer opcode encoding and the writeback record carried by the execute lanes.
package core_pkg;

    localparam int CORE_PHYS_W = 6;
    localparam int CORE_ROB_W  = 6;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_ORR = 8'h03;
    localparam logic [7:0] OP_EOR = 8'h04;
    localparam logic [7:0] OP_LSL = 8'h05;
    localparam logic [7:0] OP_LSR = 8'h06;
    localparam logic [7:0] OP_ASR = 8'h07;
    localparam logic [7:0] OP_MUL = 8'h10;

    // One completed result as broadcast on a CDB port.
    typedef struct packed {
        logic [CORE_PHYS_W-1:0] tag;
        logic [31:0]            value;
        logic [CORE_ROB_W-1:0]  rob_tag;
        logic                   exc;
    } wb_entry_t;

endpackage

// File: rtl/exec_wb_fifo.sv
// Single-lane circular writeback FIFO holding ALU results that lost the CDB port.
module exec_wb_fifo
    import core_pkg::*;
#(
    parameter int WB_DEPTH = 3,
    localparam int CNT_W = $clog2(WB_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    wb_entry_t        mem [WB_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(WB_DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push-while-full is fine then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Overflow should be unreachable while WB_DEPTH >= MUL_LAT; the entry is dropped if it happens.
    assert property (@(posedge clk) disable iff (reset) !(push && !flush && full && !do_pop));

endmodule

// File: rtl/int_exec_lanes.sv
// Integer execute stage: per-lane 1-cycle ALU, pipelined multiplier and registered CDB port.
module int_exec_lanes
    import core_pkg::*;
#(
    parameter int ISSUE_W  = 2,
    parameter int PHYS_W   = 6,
    parameter int ROB_W    = 6,
    parameter int MUL_LAT  = 3,
    parameter int WB_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_pipeline,
    input  logic [ISSUE_W-1:0]             issue_valid,
    input  logic [ISSUE_W-1:0][7:0]        issue_op,
    input  logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag,
    input  logic [ISSUE_W-1:0][31:0]       issue_src1_val,
    input  logic [ISSUE_W-1:0][31:0]       issue_src2_val,
    input  logic [ISSUE_W-1:0][ROB_W-1:0]  issue_rob_tag,
    output logic [ISSUE_W-1:0]             cdb_valid,
    output logic [ISSUE_W-1:0][PHYS_W-1:0] cdb_tag,
    output logic [ISSUE_W-1:0][31:0]       cdb_value,
    output logic [ISSUE_W-1:0][ROB_W-1:0]  cdb_rob_tag,
    output logic [ISSUE_W-1:0]             cdb_exc
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    // The FIFO absorbs at most one ALU result per cycle for as long as the
    // multiplier keeps the port, so it must be at least as deep as that run.
    if (WB_DEPTH < MUL_LAT) begin : g_bad_depth
        $error("int_exec_lanes: WB_DEPTH must be >= MUL_LAT");
    end
    if (MUL_LAT < 2) begin : g_bad_lat
        $error("int_exec_lanes: MUL_LAT must be >= 2");
    end
    if (PHYS_W != CORE_PHYS_W || ROB_W != CORE_ROB_W) begin : g_bad_tag
        $error("int_exec_lanes: tag widths must match core_pkg");
    end

    for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
        logic               take;
        logic               is_mul;
        logic               alu_vld;
        wb_entry_t          alu_res;
        wb_entry_t          mul_res;
        logic [MUL_LAT-1:1] vld_pipe;
        wb_entry_t          res_pipe [MUL_LAT-1:1];
        logic               fifo_push;
        logic               fifo_pop;
        wb_entry_t          fifo_head;
        logic [CNT_W-1:0]   fifo_cnt;
        logic               cdb_nxt_vld;
        wb_entry_t          cdb_nxt;
        logic               cdb_vld_q;
        wb_entry_t          cdb_q;

        // Ops presented during a flush are dropped.
        assign take    = issue_valid[l] && !flush_pipeline;
        assign is_mul  = (issue_op[l] == OP_MUL);
        assign alu_vld = take && !is_mul;

        // Single-cycle ALU; unknown opcodes yield 0 with the exception flag.
        always_comb begin
            alu_res         = '0;
            alu_res.tag     = issue_dst_tag[l];
            alu_res.rob_tag = issue_rob_tag[l];
            case (issue_op[l])
                OP_ADD:  alu_res.value = issue_src1_val[l] + issue_src2_val[l];
                OP_SUB:  alu_res.value = issue_src1_val[l] - issue_src2_val[l];
                OP_AND:  alu_res.value = issue_src1_val[l] & issue_src2_val[l];
                OP_ORR:  alu_res.value = issue_src1_val[l] | issue_src2_val[l];
                OP_EOR:  alu_res.value = issue_src1_val[l] ^ issue_src2_val[l];
                OP_LSL:  alu_res.value = issue_src1_val[l] << issue_src2_val[l][4:0];
                OP_LSR:  alu_res.value = issue_src1_val[l] >> issue_src2_val[l][4:0];
                OP_ASR:  alu_res.value = $unsigned($signed(issue_src1_val[l]) >>> issue_src2_val[l][4:0]);
                OP_MUL:  alu_res.value = '0;  // handled by the multiplier path
                default: alu_res.exc   = 1'b1;
            endcase
        end

        // Low 32 bits of the product, formed at issue and carried down the pipe.
        always_comb begin
            mul_res         = '0;
            mul_res.tag     = issue_dst_tag[l];
            mul_res.rob_tag = issue_rob_tag[l];
            mul_res.value   = issue_src1_val[l] * issue_src2_val[l];
        end

        // Multiplier valid shift register; flush kills every stage.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_pipe <= '0;
            end else if (flush_pipeline) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= take && is_mul;
                for (int s = 2; s < MUL_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
            end
        end

        // Multiplier payload stages, qualified by vld_pipe.
        always_ff @(posedge clk) begin
            res_pipe[1] <= mul_res;
            for (int s = 2; s < MUL_LAT; s++) res_pipe[s] <= res_pipe[s-1];
        end

        // Port select: multiplier, then FIFO head, then ALU bypass.
        always_comb begin
            cdb_nxt_vld = 1'b0;
            cdb_nxt     = '0;
            fifo_push   = 1'b0;
            fifo_pop    = 1'b0;
            if (vld_pipe[MUL_LAT-1]) begin
                cdb_nxt_vld = 1'b1;
                cdb_nxt     = res_pipe[MUL_LAT-1];
                fifo_push   = alu_vld;
            end else if (fifo_cnt != '0) begin
                cdb_nxt_vld = 1'b1;
                cdb_nxt     = fifo_head;
                fifo_pop    = 1'b1;
                fifo_push   = alu_vld;
            end else if (alu_vld) begin
                cdb_nxt_vld = 1'b1;
                cdb_nxt     = alu_res;
            end
        end

        exec_wb_fifo #(
            .WB_DEPTH (WB_DEPTH)
        ) u_wb_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush_pipeline),
            .push      (fifo_push),
            .push_data (alu_res),
            .pop       (fifo_pop),
            .head      (fifo_head),
            .count     (fifo_cnt)
        );

        // Registered CDB port; idle cycles broadcast all zeros.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cdb_vld_q <= 1'b0;
                cdb_q     <= '0;
            end else if (flush_pipeline) begin
                cdb_vld_q <= 1'b0;
                cdb_q     <= '0;
            end else begin
                cdb_vld_q <= cdb_nxt_vld;
                cdb_q     <= cdb_nxt;
            end
        end

        assign cdb_valid[l]   = cdb_vld_q;
        assign cdb_tag[l]     = cdb_q.tag;
        assign cdb_value[l]   = cdb_q.value;
        assign cdb_rob_tag[l] = cdb_q.rob_tag;
        assign cdb_exc[l]     = cdb_q.exc;
    end

endmodule

// File: tb/tb_int_exec_lanes.sv
// Bench for int_exec_lanes: directed scenarios plus random traffic against a queue-based model.
module tb_int_exec_lanes;

    localparam int ISSUE_W  = 2;
    localparam int PHYS_W   = 6;
    localparam int ROB_W    = 6;
    localparam int MUL_LAT  = 3;
    localparam int WB_DEPTH = 3;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           flush_pipeline;
    logic [ISSUE_W-1:0]             issue_valid;
    logic [ISSUE_W-1:0][7:0]        issue_op;
    logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag;
    logic [ISSUE_W-1:0][31:0]       issue_src1_val;
    logic [ISSUE_W-1:0][31:0]       issue_src2_val;
    logic [ISSUE_W-1:0][ROB_W-1:0]  issue_rob_tag;
    logic [ISSUE_W-1:0]             cdb_valid;
    logic [ISSUE_W-1:0][PHYS_W-1:0] cdb_tag;
    logic [ISSUE_W-1:0][31:0]       cdb_value;
    logic [ISSUE_W-1:0][ROB_W-1:0]  cdb_rob_tag;
    logic [ISSUE_W-1:0]             cdb_exc;

    always #5 clk = ~clk;

    int_exec_lanes #(
        .ISSUE_W (ISSUE_W), .PHYS_W (PHYS_W), .ROB_W (ROB_W),
        .MUL_LAT (MUL_LAT), .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_pipeline (flush_pipeline),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .issue_dst_tag  (issue_dst_tag),
        .issue_src1_val (issue_src1_val),
        .issue_src2_val (issue_src2_val),
        .issue_rob_tag  (issue_rob_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_rob_tag    (cdb_rob_tag),
        .cdb_exc        (cdb_exc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] val;
        logic [5:0]  rob;
        logic        exc;
    } res_t;

    typedef struct {
        int   due;
        res_t r;
    } mul_t;

    res_t wbq  [ISSUE_W][$];
    mul_t mulq [ISSUE_W][$];
    logic exp_v [ISSUE_W];
    res_t exp_r [ISSUE_W];
    int   edge_n = 0;

    function automatic res_t ref_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [5:0] tag, input logic [5:0] rob);
        res_t        r;
        int          sh;
        logic [63:0] p;
        r     = '0;
        r.tag = tag;
        r.rob = rob;
        sh    = int'(b & 32'd31);
        case (op)
            8'h00: r.val = a + b;
            8'h01: r.val = a - b;
            8'h02: r.val = a & b;
            8'h03: r.val = a | b;
            8'h04: r.val = a ^ b;
            8'h05: r.val = a << sh;
            8'h06: r.val = a >> sh;
            8'h07: r.val = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            8'h10: begin p = {32'h0, a} * {32'h0, b}; r.val = p[31:0]; end
            default: r.exc = 1'b1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < ISSUE_W; l++) begin
            wbq[l].delete();
            mulq[l].delete();
            exp_v[l] = 1'b0;
            exp_r[l] = '0;
        end
    endtask

    // Applies one clock edge worth of the port-ownership rules to each lane.
    task automatic model_edge();
        res_t alu;
        res_t m;
        logic have_alu;
        mul_t nm;
        edge_n++;
        for (int l = 0; l < ISSUE_W; l++) begin
            exp_v[l] = 1'b0;
            exp_r[l] = '0;
            if (flush_pipeline) begin
                wbq[l].delete();
                mulq[l].delete();
            end else begin
                have_alu = issue_valid[l] && issue_op[l] != 8'h10;
                alu = ref_op(issue_op[l], issue_src1_val[l], issue_src2_val[l],
                             issue_dst_tag[l], issue_rob_tag[l]);
                if (mulq[l].size() > 0 && mulq[l][0].due == edge_n) begin
                    nm = mulq[l].pop_front();
                    exp_v[l] = 1'b1;
                    exp_r[l] = nm.r;
                    if (have_alu) wbq[l].push_back(alu);
                end else if (wbq[l].size() > 0) begin
                    exp_v[l] = 1'b1;
                    exp_r[l] = wbq[l].pop_front();
                    if (have_alu) wbq[l].push_back(alu);
                end else if (have_alu) begin
                    exp_v[l] = 1'b1;
                    exp_r[l] = alu;
                end
                if (wbq[l].size() > WB_DEPTH) begin
                    check("model fifo depth", 64'(wbq[l].size()), 64'(WB_DEPTH));
                    void'(wbq[l].pop_back());
                end
                if (issue_valid[l] && issue_op[l] == 8'h10) begin
                    m = ref_op(8'h10, issue_src1_val[l], issue_src2_val[l],
                               issue_dst_tag[l], issue_rob_tag[l]);
                    nm.due = edge_n + MUL_LAT - 1;
                    nm.r   = m;
                    mulq[l].push_back(nm);
                end
            end
        end
    endtask

    task automatic cmp_out();
        for (int l = 0; l < ISSUE_W; l++) begin
            check($sformatf("L%0d valid e%0d", l, edge_n), 64'(cdb_valid[l]), 64'(exp_v[l]));
            if (exp_v[l]) begin
                check($sformatf("L%0d tag e%0d", l, edge_n), 64'(cdb_tag[l]), 64'(exp_r[l].tag));
                check($sformatf("L%0d value e%0d", l, edge_n), 64'(cdb_value[l]), 64'(exp_r[l].val));
                check($sformatf("L%0d rob e%0d", l, edge_n), 64'(cdb_rob_tag[l]), 64'(exp_r[l].rob));
                check($sformatf("L%0d exc e%0d", l, edge_n), 64'(cdb_exc[l]), 64'(exp_r[l].exc));
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_issue();
        flush_pipeline = 1'b0;
        issue_valid    = '0;
        issue_op       = '0;
        issue_dst_tag  = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        issue_rob_tag  = '0;
    endtask

    task automatic issue(input int l, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] dst, input logic [5:0] rob);
        issue_valid[l]    = 1'b1;
        issue_op[l]       = op;
        issue_src1_val[l] = a;
        issue_src2_val[l] = b;
        issue_dst_tag[l]  = dst;
        issue_rob_tag[l]  = rob;
    endtask

    // One cycle: inputs already set, clock, update model, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        cmp_out();
        clear_issue();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] op_tbl [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h06, 8'h07, 8'h10, 8'h10, 8'hFF, 8'h3C};

    initial begin
        int run;
        clear_issue();
        model_reset();
        reset = 1'b1;
        #1;
        for (int l = 0; l < ISSUE_W; l++) begin
            check("reset valid", 64'(cdb_valid[l]), 64'd0);
            check("reset tag", 64'(cdb_tag[l]), 64'd0);
            check("reset value", 64'(cdb_value[l]), 64'd0);
            check("reset rob", 64'(cdb_rob_tag[l]), 64'd0);
            check("reset exc", 64'(cdb_exc[l]), 64'd0);
        end
        idle(2);
        reset = 1'b0;
        idle(1);

        // ADD 5+7 -> next cycle
        issue(0, 8'h00, 32'd5, 32'd7, 6'd12, 6'd3);
        step();
        check("add valid", 64'(cdb_valid[0]), 64'd1);
        check("add value", 64'(cdb_value[0]), 64'd12);
        check("add tag", 64'(cdb_tag[0]), 64'd12);
        check("add rob", 64'(cdb_rob_tag[0]), 64'd3);
        check("add exc", 64'(cdb_exc[0]), 64'd0);
        idle(2);

        // MUL at t, ADD at t+2: MUL owns t+3, ADD drains at t+4
        issue(0, 8'h10, 32'd3, 32'd4, 6'd1, 6'd1);
        step();
        step();
        issue(0, 8'h00, 32'd1, 32'd1, 6'd2, 6'd2);
        step();
        check("mul value", 64'(cdb_value[0]), 64'd12);
        check("mul tag", 64'(cdb_tag[0]), 64'd1);
        step();
        check("drained add value", 64'(cdb_value[0]), 64'd2);
        check("drained add valid", 64'(cdb_valid[0]), 64'd1);
        idle(3);

        // Lane1 MUL x3 then ADD x3 back to back: six consecutive results
        run = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) issue(1, (i < 3) ? 8'h10 : 8'h00, 32'(i + 2), 32'd3, 6'(20 + i), 6'(40 + i));
            step();
            if (i >= 2 && cdb_valid[1]) run++;
        end
        check("l1 burst count", 64'(run), 64'd6);
        idle(3);

        // Shift / subtract / illegal
        issue(0, 8'h07, 32'h80000000, 32'd33, 6'd5, 6'd6);
        issue(1, 8'h01, 32'd0, 32'd1, 6'd7, 6'd8);
        step();
        check("asr by 33", 64'(cdb_value[0]), 64'hC0000000);
        check("sub wrap", 64'(cdb_value[1]), 64'hFFFFFFFF);
        issue(0, 8'hFF, 32'd9, 32'd9, 6'd9, 6'd9);
        step();
        check("illegal value", 64'(cdb_value[0]), 64'd0);
        check("illegal exc", 64'(cdb_exc[0]), 64'd1);
        idle(2);

        // Flush with MUL in flight and two FIFO entries, plus an issue in the flush cycle
        issue(0, 8'h10, 32'd6, 32'd7, 6'd10, 6'd10);
        step();
        issue(0, 8'h10, 32'd8, 32'd9, 6'd11, 6'd11);
        step();
        issue(0, 8'h00, 32'd2, 32'd3, 6'd12, 6'd12);
        step();
        issue(0, 8'h00, 32'd4, 32'd5, 6'd13, 6'd13);
        issue(1, 8'h10, 32'd5, 32'd5, 6'd14, 6'd14);
        step();
        flush_pipeline = 1'b1;
        issue(0, 8'h00, 32'd1, 32'd2, 6'd15, 6'd15);
        issue(1, 8'h00, 32'd1, 32'd2, 6'd16, 6'd16);
        step();
        for (int i = 0; i < 6; i++) begin
            check("post-flush idle", 64'(cdb_valid), 64'd0);
            step();
        end

        // Asynchronous reset between edges with work in flight
        issue(0, 8'h10, 32'd11, 32'd11, 6'd20, 6'd20);
        issue(1, 8'h00, 32'd1, 32'd1, 6'd21, 6'd21);
        step();
        issue(0, 8'h00, 32'd2, 32'd2, 6'd22, 6'd22);
        issue(1, 8'h10, 32'd3, 32'd3, 6'd23, 6'd23);
        step();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async reset valid", 64'(cdb_valid), 64'd0);
        check("async reset value0", 64'(cdb_value[0]), 64'd0);
        step();
        reset = 1'b0;
        step();
        issue(0, 8'h00, 32'd40, 32'd2, 6'd30, 6'd31);
        step();
        check("post-reset add valid", 64'(cdb_valid[0]), 64'd1);
        check("post-reset add value", 64'(cdb_value[0]), 64'd42);
        idle(4);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            flush_pipeline = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < ISSUE_W; l++) begin
                if ($urandom_range(0, 3) != 0)
                    issue(l, op_tbl[$urandom_range(0, 11)], $urandom(),
                          ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 70)) : $urandom(),
                          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            end
            step();
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
